// File: rtl/sd_frame_dump.sv
// Streams 16-bit source words into consecutive SD sectors through the sd_ctrl_top write port.
// One sector = one prefetched word plus up to SEC_WORDS-1 words fetched on demand from wr_req.
module sd_frame_dump #(
    parameter int SEC_WORDS   = 256,
    parameter int DEF_SEC_NUM = 3072
) (
    input  logic        clk_50m,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] start_sec_addr,
    input  logic [15:0] sec_num,
    output logic        src_rd_en,
    input  logic [15:0] src_rd_data,
    input  logic        src_empty,
    output logic        wr_start_en,
    output logic [31:0] wr_sec_addr,
    output logic [15:0] wr_data,
    input  logic        wr_busy,
    input  logic        wr_req,
    output logic        busy,
    output logic        done,
    output logic        underflow,
    output logic [15:0] sec_cnt
);

    // The word counter is 9 bits wide and sec_cnt is 16 bits wide.
    if (SEC_WORDS < 2 || SEC_WORDS > 256 || DEF_SEC_NUM < 0 || DEF_SEC_NUM > 65535) begin : g_bad_param
        $error("sd_frame_dump: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE, PREFETCH, LOAD, START, WAIT_HI, XFER, NEXT, DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] base_addr;
    logic [15:0] sec_total;
    logic [8:0]  word_cnt;
    logic        zero_word;
    logic        load_pend;
    logic        fetch;

    always_comb begin
        state_nxt = state;
        src_rd_en = 1'b0;
        fetch     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (sec_num == 16'd0) ? DONE : PREFETCH;
            end
            PREFETCH: begin
                src_rd_en = ~src_empty;
                state_nxt = LOAD;
            end
            LOAD:    state_nxt = START;
            START:   state_nxt = WAIT_HI;
            WAIT_HI: begin
                if (wr_busy) state_nxt = XFER;
            end
            XFER: begin
                // Word 0 came from the prefetch, so only the first SEC_WORDS-1 requests fetch.
                if (wr_req && word_cnt < 9'(SEC_WORDS - 1)) begin
                    fetch     = 1'b1;
                    src_rd_en = ~src_empty;
                end
                if (!wr_busy) state_nxt = NEXT;
            end
            NEXT:    state_nxt = (sec_cnt + 16'd1 == sec_total) ? DONE : PREFETCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign wr_start_en = (state == START);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            base_addr   <= 32'd0;
            sec_total   <= 16'd0;
            sec_cnt     <= 16'd0;
            underflow   <= 1'b0;
            zero_word   <= 1'b0;
            load_pend   <= 1'b0;
            word_cnt    <= 9'd0;
            wr_data     <= 16'd0;
            wr_sec_addr <= 32'd0;
        end else begin
            state     <= state_nxt;
            load_pend <= fetch;
            if (state == IDLE && start) begin
                base_addr <= start_sec_addr;
                sec_total <= sec_num;
                sec_cnt   <= 16'd0;
                underflow <= 1'b0;
            end
            // An empty source still consumes a word slot; it is replaced by zero.
            if (state == PREFETCH || fetch) begin
                zero_word <= src_empty;
                if (src_empty) underflow <= 1'b1;
            end
            if (state == LOAD || load_pend) begin
                wr_data <= zero_word ? 16'd0 : src_rd_data;
            end
            if (state == LOAD) begin
                word_cnt    <= 9'd0;
                wr_sec_addr <= base_addr + {16'd0, sec_cnt};
            end
            if (state == XFER && wr_req && word_cnt != 9'(SEC_WORDS)) begin
                word_cnt <= word_cnt + 9'd1;
            end
            if (state == NEXT) sec_cnt <= sec_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_sd_frame_dump.sv
// Testbench for sd_frame_dump: random source data and random wr_req spacing against a word-order model.
module tb_sd_frame_dump;
    localparam int SW = 256;
    localparam int MEM_N = 8192;

    logic        clk_50m = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] start_sec_addr = 32'd0;
    logic [15:0] sec_num = 16'd0;
    logic        src_rd_en;
    logic [15:0] src_rd_data = 16'd0;
    logic        src_empty = 1'b0;
    logic        wr_start_en;
    logic [31:0] wr_sec_addr;
    logic [15:0] wr_data;
    logic        wr_busy = 1'b0;
    logic        wr_req = 1'b0;
    logic        busy;
    logic        done;
    logic        underflow;
    logic [15:0] sec_cnt;

    int errors = 0;
    int checks = 0;

    logic [15:0] src_mem [0:MEM_N-1];
    int          src_ptr = 0;
    int          exp_ptr = 0;
    logic [31:0] exp_base = 32'd0;
    int          nreq = SW;
    bit          empty_on = 1'b0;
    int          sec_idx = 0;
    int          cur_j = -1;
    bit          ctl_abort = 1'b0;
    int          n_done = 0;
    int          n_wse = 0;

    always #10 clk_50m = ~clk_50m;

    sd_frame_dump #(.SEC_WORDS(SW), .DEF_SEC_NUM(3072)) dut (
        .clk_50m(clk_50m), .rst_n(rst_n), .start(start),
        .start_sec_addr(start_sec_addr), .sec_num(sec_num),
        .src_rd_en(src_rd_en), .src_rd_data(src_rd_data), .src_empty(src_empty),
        .wr_start_en(wr_start_en), .wr_sec_addr(wr_sec_addr), .wr_data(wr_data),
        .wr_busy(wr_busy), .wr_req(wr_req),
        .busy(busy), .done(done), .underflow(underflow), .sec_cnt(sec_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_empty(input int s, input int w);
        return empty_on && s == 0 && w >= 10 && w <= 12;
    endfunction

    // Source: a word requested in one cycle appears on src_rd_data the next cycle.
    initial begin : source
        bit take;
        forever begin
            @(negedge clk_50m);
            take = src_rd_en;
            @(posedge clk_50m);
            #1;
            if (take) begin
                src_rd_data = src_mem[src_ptr % MEM_N];
                src_ptr++;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk_50m);
            if (done) n_done++;
            if (wr_start_en) n_wse++;
        end
    end

    // SD controller model: the expected word for request j is the next unconsumed source
    // word, zero where the source was empty, and the last real word for requests past SW.
    initial begin : ctl
        logic [15:0] last_w;
        logic [15:0] exp_w;
        forever begin
            @(negedge clk_50m);
            if (wr_start_en && !ctl_abort) begin
                check("wr_sec_addr", wr_sec_addr, exp_base + 32'(sec_idx));
                @(posedge clk_50m);
                #1 wr_busy = 1'b1;
                repeat ($urandom_range(1, 3)) @(posedge clk_50m);
                #1;
                last_w = 16'd0;
                for (int j = 0; j < nreq && !ctl_abort; j++) begin
                    cur_j = j;
                    if (j < SW) begin
                        if (is_empty(sec_idx, j)) exp_w = 16'd0;
                        else begin
                            exp_w = src_mem[exp_ptr % MEM_N];
                            exp_ptr++;
                        end
                        last_w = exp_w;
                    end else begin
                        exp_w = last_w;
                    end
                    wr_req = 1'b1;
                    src_empty = is_empty(sec_idx, j + 1);
                    @(negedge clk_50m);
                    if (!ctl_abort) check("wr_data", 32'(wr_data), 32'(exp_w));
                    @(posedge clk_50m);
                    #1 wr_req = 1'b0;
                    src_empty = 1'b0;
                    repeat (2 + $urandom_range(0, 2)) @(posedge clk_50m);
                    #1;
                end
                wr_busy = 1'b0;
                wr_req = 1'b0;
                src_empty = 1'b0;
                cur_j = -1;
                sec_idx++;
            end
        end
    end

    task automatic run_dump(input logic [31:0] base, input logic [15:0] num, input int req_n,
                            input bit emp, input bit second_start);
        int d0;
        int s0;
        int p0;
        int waited;
        bit got;
        exp_base = base;
        nreq = req_n;
        empty_on = emp;
        sec_idx = 0;
        d0 = n_done;
        s0 = n_wse;
        p0 = src_ptr;
        @(posedge clk_50m);
        #1 start = 1'b1;
        start_sec_addr = base;
        sec_num = num;
        @(posedge clk_50m);
        #1 start = 1'b0;
        start_sec_addr = $urandom;
        sec_num = 16'($urandom_range(1, 60000));
        @(negedge clk_50m);
        check("busy_after_start", 32'(busy), 32'd1);
        check("underflow_cleared", 32'(underflow), 32'd0);
        if (num != 16'd0) begin
            check("src_rd_en_prefetch", 32'(src_rd_en), 32'd1);
            @(negedge clk_50m);
            @(negedge clk_50m);
            check("wr_start_en_latency", 32'(wr_start_en), 32'd1);
            check("wr_data_first", 32'(wr_data), 32'(src_mem[p0 % MEM_N]));
            if (second_start) begin
                @(posedge clk_50m);
                #1 start = 1'b1;
                @(posedge clk_50m);
                #1 start = 1'b0;
            end
        end
        got = 1'b0;
        waited = 0;
        for (int i = 0; i < int'(num) * 2048 + 50; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            waited++;
            @(negedge clk_50m);
        end
        check("done_seen", 32'(got), 32'd1);
        if (num == 16'd0) check("zero_done_latency_ok", 32'(waited <= 1), 32'd1);
        check("sec_cnt_at_done", 32'(sec_cnt), 32'(num));
        check("busy_in_done", 32'(busy), 32'd1);
        @(negedge clk_50m);
        check("busy_after_done", 32'(busy), 32'd0);
        repeat (4) @(negedge clk_50m);
        check("done_pulses", 32'(n_done - d0), 32'd1);
        check("sector_starts", 32'(n_wse - s0), 32'(num));
        check("source_reads", 32'(src_ptr), 32'(exp_ptr));
        check("underflow_sticky", 32'(underflow), 32'(emp));
        check("sec_cnt_hold", 32'(sec_cnt), 32'(num));
    endtask

    initial begin : main
        int p;
        int d0;
        int s0;
        bit reached;
        for (int i = 0; i < MEM_N; i++) src_mem[i] = 16'($urandom);

        #5 rst_n = 1'b0;
        repeat (3) @(negedge clk_50m);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_src_rd_en", 32'(src_rd_en), 32'd0);
        check("rst_wr_start_en", 32'(wr_start_en), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_wr_sec_addr", wr_sec_addr, 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_sec_cnt", 32'(sec_cnt), 32'd0);
        @(posedge clk_50m);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk_50m);

        p = src_ptr;
        run_dump(32'h0000_1000, 16'd1, SW, 1'b0, 1'b0);
        check("single_reads", 32'(src_ptr - p), 32'd256);

        run_dump(32'hFFFF_FFFE, 16'd4, SW, 1'b0, 1'b0);

        p = src_ptr;
        run_dump($urandom, 16'd1, SW, 1'b1, 1'b0);
        check("underflow_reads", 32'(src_ptr - p), 32'd253);

        run_dump($urandom, 16'd2, SW, 1'b0, 1'b1);

        p = src_ptr;
        run_dump(32'h0000_0055, 16'd0, SW, 1'b0, 1'b0);
        check("zero_count_reads", 32'(src_ptr - p), 32'd0);

        p = src_ptr;
        run_dump($urandom, 16'd1, SW + 2, 1'b0, 1'b0);
        check("extra_req_reads", 32'(src_ptr - p), 32'd256);

        // Reset while sector 2 of a 3-sector dump is transferring.
        exp_base = 32'h0000_2000;
        nreq = SW;
        empty_on = 1'b0;
        sec_idx = 0;
        d0 = n_done;
        @(posedge clk_50m);
        #1 start = 1'b1;
        start_sec_addr = 32'h0000_2000;
        sec_num = 16'd3;
        @(posedge clk_50m);
        #1 start = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk_50m);
            if (sec_idx == 2 && cur_j >= 20) begin
                reached = 1'b1;
                break;
            end
        end
        check("reached_sector2", 32'(reached), 32'd1);
        ctl_abort = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_src_rd_en", 32'(src_rd_en), 32'd0);
        check("midrst_wr_start_en", 32'(wr_start_en), 32'd0);
        check("midrst_wr_sec_addr", wr_sec_addr, 32'd0);
        check("midrst_wr_data", 32'(wr_data), 32'd0);
        check("midrst_sec_cnt", 32'(sec_cnt), 32'd0);
        s0 = n_wse;
        repeat (10) @(negedge clk_50m);
        check("midrst_no_done", 32'(n_done - d0), 32'd0);
        check("midrst_no_wse", 32'(n_wse - s0), 32'd0);
        rst_n = 1'b1;
        ctl_abort = 1'b0;
        repeat (2) @(negedge clk_50m);
        exp_ptr = src_ptr;
        run_dump(32'hABC0_0000, 16'd2, SW, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
